// File: rtl/thor2022_bitfield_issue.sv
// Issue stage for the combinational bitfield unit: captures one operation,
// executes it for one cycle and buffers the result in a 2-entry writeback FIFO.
module thor2022_bitfield_issue #(
   parameter int unsigned WID = 128,
   parameter int unsigned IRW = 48,
   parameter int unsigned TGW = 6
) (
   input  logic           clk_i,
   input  logic           rst_i,
   input  logic           flush_i,
   input  logic           req_i,
   output logic           rdy_o,
   input  logic [IRW-1:0] ir_i,
   input  logic [WID-1:0] a_i,
   input  logic [WID-1:0] b_i,
   input  logic [WID-1:0] c_i,
   input  logic [TGW-1:0] tgt_i,
   output logic [IRW-1:0] bf_ir_o,
   output logic [WID-1:0] bf_a_o,
   output logic [WID-1:0] bf_b_o,
   output logic [WID-1:0] bf_c_o,
   input  logic [WID-1:0] bf_res_i,
   output logic           wb_v_o,
   output logic [TGW-1:0] wb_tgt_o,
   output logic [WID-1:0] wb_res_o,
   input  logic           wb_ack_i,
   output logic           busy_o
);

   typedef enum logic {
      IDLE = 1'b0,
      EXEC = 1'b1
   } state_t;

   state_t         state_q;
   state_t         state_d;
   logic [TGW-1:0] tgt_q;
   logic [1:0]     cnt_q;
   logic           wptr_q;
   logic           rptr_q;
   logic [TGW-1:0] qtgt [2];
   logic [WID-1:0] qres [2];
   logic           issue;
   logic           push;
   logic           pop;

   // Handshake qualifiers; flush suppresses every queue side effect.
   always_comb begin
      pop   = wb_v_o & wb_ack_i & ~flush_i;
      push  = (state_q == EXEC) & ~flush_i;
      rdy_o = ~flush_i & (((state_q == IDLE) && (cnt_q != 2'd2)) ||
                          ((state_q == EXEC) && (cnt_q == 2'd0)) ||
                          ((cnt_q == 2'd1) && pop));
      issue = req_i & rdy_o;
   end

   // Next-state logic: EXEC lasts one cycle unless a back-to-back issue lands.
   always_comb begin
      state_d = state_q;
      if (flush_i) begin
         state_d = IDLE;
      end else begin
         unique case (state_q)
            IDLE: if (issue) state_d = EXEC;
            EXEC: state_d = issue ? EXEC : IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // State register.
   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Operand capture on a completed issue; held otherwise.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         bf_ir_o <= '0;
         bf_a_o  <= '0;
         bf_b_o  <= '0;
         bf_c_o  <= '0;
         tgt_q   <= '0;
      end else if (issue) begin
         bf_ir_o <= ir_i;
         bf_a_o  <= a_i;
         bf_b_o  <= b_i;
         bf_c_o  <= c_i;
         tgt_q   <= tgt_i;
      end
   end

   // Result FIFO: EXEC result written at the tail, head popped on ack.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q  <= '0;
         wptr_q <= 1'b0;
         rptr_q <= 1'b0;
         for (int unsigned i = 0; i < 2; i++) begin
            qtgt[i] <= '0;
            qres[i] <= '0;
         end
      end else if (flush_i) begin
         cnt_q  <= '0;
         wptr_q <= 1'b0;
         rptr_q <= 1'b0;
      end else begin
         if (push) begin
            qtgt[wptr_q] <= tgt_q;
            qres[wptr_q] <= bf_res_i;
            wptr_q       <= ~wptr_q;
         end
         if (pop) rptr_q <= ~rptr_q;
         unique case ({push, pop})
            2'b10:   cnt_q <= cnt_q + 2'd1;
            2'b01:   cnt_q <= cnt_q - 2'd1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   // Head of the FIFO drives the writeback port.
   always_comb begin
      wb_v_o   = (cnt_q != 2'd0);
      wb_tgt_o = qtgt[rptr_q];
      wb_res_o = qres[rptr_q];
      busy_o   = (state_q == EXEC) || (cnt_q != 2'd0);
   end

   // The rdy_o qualification keeps a slot free for every EXEC result.
   a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
      !(push && (cnt_q == 2'd2)));

endmodule

// File: tb/tb_thor2022_bitfield_issue.sv
// Scoreboard bench: stimulus queues expected writebacks, a monitor pops and
// compares them on every accepted writeback.
module tb_thor2022_bitfield_issue;

   logic         clk_i = 1'b0;
   logic         rst_i;
   logic         flush_i;
   logic         req_i;
   logic         rdy_o;
   logic [47:0]  ir_i;
   logic [127:0] a_i;
   logic [127:0] b_i;
   logic [127:0] c_i;
   logic [5:0]   tgt_i;
   logic [47:0]  bf_ir_o;
   logic [127:0] bf_a_o;
   logic [127:0] bf_b_o;
   logic [127:0] bf_c_o;
   logic [127:0] bf_res_i;
   logic         wb_v_o;
   logic [5:0]   wb_tgt_o;
   logic [127:0] wb_res_o;
   logic         wb_ack_i;
   logic         busy_o;

   int checks = 0;
   int fails  = 0;
   int pops   = 0;
   logic [133:0] sb [$];

   thor2022_bitfield_issue #(.WID(128), .IRW(48), .TGW(6)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .req_i(req_i),
      .rdy_o(rdy_o), .ir_i(ir_i), .a_i(a_i), .b_i(b_i), .c_i(c_i),
      .tgt_i(tgt_i), .bf_ir_o(bf_ir_o), .bf_a_o(bf_a_o), .bf_b_o(bf_b_o),
      .bf_c_o(bf_c_o), .bf_res_i(bf_res_i), .wb_v_o(wb_v_o),
      .wb_tgt_o(wb_tgt_o), .wb_res_o(wb_res_o), .wb_ack_i(wb_ack_i),
      .busy_o(busy_o)
   );

   // Bitfield unit model: result is operand a.
   assign bf_res_i = bf_a_o;

   always #5 clk_i = ~clk_i;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   // Drive one issue request; acc is the hand-derived rdy_o for this cycle.
   task automatic drv(input logic [5:0] t, input logic [127:0] a, input bit acc);
      req_i = 1'b1;
      tgt_i = t;
      a_i   = a;
      b_i   = ~a;
      c_i   = {a[63:0], a[127:64]};
      ir_i  = {42'h155, t};
      #1;
      chk($sformatf("rdy_tag%0d", t), {127'd0, rdy_o}, {127'd0, acc});
      if (acc) sb.push_back({t, a});
   endtask

   // Monitor: every accepted writeback must match the scoreboard head.
   always @(negedge clk_i) begin
      if (!rst_i && wb_v_o && wb_ack_i && !flush_i) begin
         pops++;
         if (sb.size() == 0) begin
            chk("unexpected_wb", {122'd0, wb_tgt_o}, 128'd0);
         end else begin
            logic [133:0] e;
            e = sb.pop_front();
            chk("wb_tgt", {122'd0, wb_tgt_o}, {122'd0, e[133:128]});
            chk("wb_res", wb_res_o, e[127:0]);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_i = 1'b1; flush_i = 1'b0; req_i = 1'b0; wb_ack_i = 1'b0;
      ir_i = '0; a_i = '0; b_i = '0; c_i = '0; tgt_i = '0;
      tick(); tick();
      chk("rst_wb_v", {127'd0, wb_v_o}, 128'd0);
      chk("rst_busy", {127'd0, busy_o}, 128'd0);
      chk("rst_bf_a", bf_a_o, 128'd0);
      chk("rst_bf_ir", {80'd0, bf_ir_o}, 128'd0);
      chk("rst_wb_res", wb_res_o, 128'd0);
      rst_i = 1'b0;
      #1 chk("rst_rdy", {127'd0, rdy_o}, 128'd1);

      // Single issue, 2-cycle latency, one-cycle valid.
      wb_ack_i = 1'b1;
      drv(6'd5, 128'h1234, 1'b1);
      tick();
      req_i = 1'b0;
      chk("t1_bf_a", bf_a_o, 128'h1234);
      chk("t1_bf_b", bf_b_o, ~128'h1234);
      chk("t1_bf_ir", {80'd0, bf_ir_o}, {80'd0, 42'h155, 6'd5});
      chk("t1_wb_v_n", {127'd0, wb_v_o}, 128'd0);
      tick();
      chk("t1_wb_v_n1", {127'd0, wb_v_o}, 128'd1);
      chk("t1_tgt", {122'd0, wb_tgt_o}, 128'd5);
      tick();
      chk("t1_wb_v_n2", {127'd0, wb_v_o}, 128'd0);
      chk("t1_busy", {127'd0, busy_o}, 128'd0);

      // Back-to-back issue of tags 1,2,3.
      drv(6'd1, 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210, 1'b1);
      tick();
      drv(6'd2, 128'hffff_0000_ffff_0000_a5a5_5a5a_0f0f_f0f0, 1'b1);
      tick();
      drv(6'd3, 128'h8000_0000_0000_0000_0000_0000_0000_0001, 1'b1);
      tick();
      req_i = 1'b0;
      chk("t2_head1", {122'd0, wb_tgt_o}, 128'd2);
      tick();
      chk("t2_head2", {122'd0, wb_tgt_o}, 128'd3);
      tick();
      chk("t2_empty", {127'd0, wb_v_o}, 128'd0);

      // Backpressure: queue fills, rdy drops, then drains in order.
      wb_ack_i = 1'b0;
      drv(6'd10, 128'hA0, 1'b1);
      tick();
      drv(6'd11, 128'hB1, 1'b1);
      tick();
      drv(6'd12, 128'hC2, 1'b0);
      tick();
      chk("t3_head", {122'd0, wb_tgt_o}, 128'd10);
      drv(6'd12, 128'hC2, 1'b0);
      tick();
      req_i = 1'b0;
      wb_ack_i = 1'b1;
      #1 chk("t3_rdy_pop_full", {127'd0, rdy_o}, 128'd0);
      tick();
      chk("t3_head2", {122'd0, wb_tgt_o}, 128'd11);
      chk("t3_rdy_back", {127'd0, rdy_o}, 128'd1);
      tick();
      chk("t3_empty", {127'd0, wb_v_o}, 128'd0);

      // Flush in EXEC with one entry queued.
      wb_ack_i = 1'b0;
      drv(6'd20, 128'hD0, 1'b1);
      tick();
      drv(6'd21, 128'hE1, 1'b1);
      tick();
      flush_i = 1'b1;
      wb_ack_i = 1'b1;
      drv(6'd22, 128'hF2, 1'b0);
      tick();
      flush_i = 1'b0;
      req_i = 1'b0;
      sb.delete();
      chk("t4_wb_v", {127'd0, wb_v_o}, 128'd0);
      chk("t4_busy", {127'd0, busy_o}, 128'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t4_stale", {127'd0, wb_v_o}, 128'd0);
      end

      // Reset in EXEC with a queued entry.
      wb_ack_i = 1'b0;
      drv(6'd30, 128'h30, 1'b1);
      tick();
      req_i = 1'b0;
      tick();
      drv(6'd31, 128'h31, 1'b1);
      tick();
      req_i = 1'b0;
      rst_i = 1'b1;
      tick();
      sb.delete();
      chk("t5_wb_v", {127'd0, wb_v_o}, 128'd0);
      chk("t5_busy", {127'd0, busy_o}, 128'd0);
      chk("t5_tgt", {122'd0, wb_tgt_o}, 128'd0);
      chk("t5_res", wb_res_o, 128'd0);
      chk("t5_bf_a", bf_a_o, 128'd0);
      chk("t5_bf_c", bf_c_o, 128'd0);
      rst_i = 1'b0;
      #1 chk("t5_rdy", {127'd0, rdy_o}, 128'd1);
      tick();

      // Push and pop together at count 1.
      drv(6'd40, 128'h4040, 1'b1);
      tick();
      req_i = 1'b0;
      tick();
      drv(6'd41, 128'h4141, 1'b1);
      tick();
      req_i = 1'b0;
      wb_ack_i = 1'b1;
      #1 chk("t6_rdy", {127'd0, rdy_o}, 128'd1);
      chk("t6_head0", {122'd0, wb_tgt_o}, 128'd40);
      tick();
      chk("t6_wb_v", {127'd0, wb_v_o}, 128'd1);
      chk("t6_head1", {122'd0, wb_tgt_o}, 128'd41);
      tick();
      chk("t6_empty", {127'd0, wb_v_o}, 128'd0);
      wb_ack_i = 1'b0;
      tick();

      chk("sb_drained", sb.size(), 128'd0);
      chk("pop_total", pops, 128'd8);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
